// File: rtl/noc_serial_pkg.sv
// Shared definitions for the serial NoC endpoints: header layout, flit type,
// FSM state encoding and the body-flit count helper.
package noc_serial_pkg;

    localparam int ADDR_BITS       = 4;
    localparam int HDR_BITS        = 16;
    localparam int HDR_DST_ROW_LSB = 12;
    localparam int HDR_DST_COL_LSB = 8;
    localparam int HDR_SRC_ROW_LSB = 4;
    localparam int HDR_SRC_COL_LSB = 0;
    localparam int FLIT_BITS       = 16;

    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef struct packed {
        logic                 last;
        logic [FLIT_BITS-1:0] data;
    } flit_t;

    typedef enum logic [2:0] {
        RX_HEAD  = 3'd0,
        RX_BODY  = 3'd1,
        REQ      = 3'd2,
        WAIT_RSP = 3'd3,
        TX_HEAD  = 3'd4,
        TX_BODY  = 3'd5
    } state_e;

    typedef enum logic {
        SHIFT_RX = 1'b0,
        SHIFT_TX = 1'b1
    } shift_dir_e;

    // Number of body flits needed to carry body_bits, rounded up.
    function automatic int calc_nb(input int body_bits, input int flit_bits);
        return (body_bits + flit_bits - 1) / flit_bits;
    endfunction

    function automatic logic [HDR_BITS-1:0] make_header(input addr_t dst_row, input addr_t dst_col,
                                                        input addr_t src_row, input addr_t src_col);
        logic [HDR_BITS-1:0] h;
        h = '0;
        h[HDR_DST_ROW_LSB +: ADDR_BITS] = dst_row;
        h[HDR_DST_COL_LSB +: ADDR_BITS] = dst_col;
        h[HDR_SRC_ROW_LSB +: ADDR_BITS] = src_row;
        h[HDR_SRC_COL_LSB +: ADDR_BITS] = src_col;
        return h;
    endfunction

endpackage

// File: rtl/noc_flit_shifter.sv
// LSB-first flit shift register. RX fills from the top so the first flit ends
// up in the low bits; TX loads a whole word and drains the low flit each shift.
module noc_flit_shifter
    import noc_serial_pkg::*;
#(
    parameter shift_dir_e DIR       = SHIFT_RX,
    parameter int         FLIT_BITS = 16,
    parameter int         NB        = 3,
    parameter int         OUT_BITS  = FLIT_BITS,
    localparam int        SR_BITS   = NB * FLIT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [SR_BITS-1:0]   load_data_i,
    input  logic                 shift_i,
    input  logic [FLIT_BITS-1:0] flit_i,
    output logic [OUT_BITS-1:0]  data_o
);

    logic [SR_BITS-1:0] sr_q, sr_d, fill;

    always_comb begin
        fill = (DIR == SHIFT_RX) ? (SR_BITS'(flit_i) << (SR_BITS - FLIT_BITS)) : '0;
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_i) begin
            sr_d = (sr_q >> FLIT_BITS) | fill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign data_o = sr_q[OUT_BITS-1:0];

endmodule

// File: rtl/noc_serial_responder.sv
// Serial NoC responder: receives a request packet, hands it to the user, and
// returns the user's response to the sender. Optional framing check: NOC_RESPONDER_LEN_CHECK_EN.
module noc_serial_responder
    import noc_serial_pkg::*;
#(
    parameter int    PACKET_BITS    = 42,
    parameter int    PADDING_BITS   = 4,
    parameter int    FLIT_DATA_BITS = 16,
    parameter addr_t OWN_ROW        = 4'd0,
    parameter addr_t OWN_COL        = 4'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [FLIT_DATA_BITS-1:0] in_data,
    output logic                      in_ack,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [FLIT_DATA_BITS-1:0] out_data,
    input  logic                      out_ack,
    output logic                      req_valid,
    output logic [PADDING_BITS-1:0]   req_padding,
    output logic [PACKET_BITS-1:0]    req_packet,
    input  logic                      req_ready,
    input  logic                      rsp_valid,
    input  logic [PADDING_BITS-1:0]   rsp_padding,
    input  logic [PACKET_BITS-1:0]    rsp_packet,
    output logic                      rsp_ack,
    output state_e                    dbg_state
`ifdef NOC_RESPONDER_LEN_CHECK_EN
    ,
    output logic                      err
`endif
);

    localparam int BODY_BITS = PADDING_BITS + PACKET_BITS;
    localparam int NB        = calc_nb(BODY_BITS, FLIT_DATA_BITS);
    localparam int SR_BITS   = NB * FLIT_DATA_BITS;
    localparam int CNT_W     = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    addr_t               src_row_q, src_row_d, src_col_q, src_col_d;
    logic                rx_clear, rx_shift, tx_load, tx_shift, last_body;
    logic [BODY_BITS-1:0]      rx_word;
    logic [FLIT_DATA_BITS-1:0] tx_flit;

`ifdef NOC_RESPONDER_LEN_CHECK_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    noc_flit_shifter #(
        .DIR(SHIFT_RX), .FLIT_BITS(FLIT_DATA_BITS), .NB(NB), .OUT_BITS(BODY_BITS)
    ) u_rx_shifter (
        .clk(clk), .rst(rst), .load_i(rx_clear), .load_data_i('0),
        .shift_i(rx_shift), .flit_i(in_data), .data_o(rx_word)
    );

    noc_flit_shifter #(
        .DIR(SHIFT_TX), .FLIT_BITS(FLIT_DATA_BITS), .NB(NB), .OUT_BITS(FLIT_DATA_BITS)
    ) u_tx_shifter (
        .clk(clk), .rst(rst), .load_i(tx_load),
        .load_data_i(SR_BITS'({rsp_padding, rsp_packet})),
        .shift_i(tx_shift), .flit_i('0), .data_o(tx_flit)
    );

    // The receive register holds still from REQ onward, so the request is stable until taken.
    assign {req_padding, req_packet} = rx_word;
    assign dbg_state = state_q;
    assign last_body = (cnt_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_row_d = src_row_q;
        src_col_d = src_col_q;
        in_ack    = 1'b0;
        req_valid = 1'b0;
        rsp_ack   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        rx_clear  = 1'b0;
        rx_shift  = 1'b0;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
`ifdef NOC_RESPONDER_LEN_CHECK_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            RX_HEAD: begin
                in_ack = in_valid;
                if (in_valid) begin
                    src_row_d = in_data[HDR_SRC_ROW_LSB +: ADDR_BITS];
                    src_col_d = in_data[HDR_SRC_COL_LSB +: ADDR_BITS];
                    cnt_d     = '0;
                    rx_clear  = 1'b1;
                    state_d   = RX_BODY;
                end
            end
            RX_BODY: begin
                in_ack = in_valid;
                if (in_valid) begin
                    rx_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
`ifdef NOC_RESPONDER_LEN_CHECK_EN
                    if (in_last != last_body) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = RX_HEAD;
                    end else if (last_body) begin
                        cnt_d   = '0;
                        state_d = REQ;
                    end
`else
                    if (last_body) begin
                        cnt_d   = '0;
                        state_d = REQ;
                    end
`endif
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                rsp_ack = rsp_valid;
                if (rsp_valid) begin
                    tx_load = 1'b1;
                    state_d = TX_HEAD;
                end
            end
            TX_HEAD: begin
                out_valid = 1'b1;
                out_data  = FLIT_DATA_BITS'(make_header(src_row_q, src_col_q, OWN_ROW, OWN_COL));
                if (out_ack) begin
                    cnt_d   = '0;
                    state_d = TX_BODY;
                end
            end
            TX_BODY: begin
                out_valid = 1'b1;
                out_data  = tx_flit;
                out_last  = last_body;
                if (out_ack) begin
                    tx_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_body) begin
                        cnt_d   = '0;
                        state_d = RX_HEAD;
                    end
                end
            end
            default: state_d = RX_HEAD;
        endcase
        // Handshake outputs are forced quiet while reset is held.
        if (rst) begin
            in_ack    = 1'b0;
            rsp_ack   = 1'b0;
            req_valid = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
            out_data  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_HEAD;
            cnt_q     <= '0;
            src_row_q <= '0;
            src_col_q <= '0;
`ifdef NOC_RESPONDER_LEN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_row_q <= src_row_d;
            src_col_q <= src_col_d;
`ifdef NOC_RESPONDER_LEN_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_noc_serial_responder.sv
// Scoreboard bench for noc_serial_responder: directed cases plus random traffic
// against a word-level packet model. Framing-error case runs with NOC_RESPONDER_LEN_CHECK_EN.
module tb_noc_serial_responder;
    import noc_serial_pkg::*;

    localparam int PKT = 42;
    localparam int PAD = 4;
    localparam int FW  = 16;
    localparam int BW  = PAD + PKT;
    localparam int NB  = (BW + FW - 1) / FW;
    localparam logic [3:0] OWN_R = 4'd0;
    localparam logic [3:0] OWN_C = 4'd0;

    logic clk, rst;
    logic in_valid, in_last, in_ack;
    logic [FW-1:0] in_data;
    logic out_valid, out_last, out_ack;
    logic [FW-1:0] out_data;
    logic req_valid, req_ready;
    logic [PAD-1:0] req_padding;
    logic [PKT-1:0] req_packet;
    logic rsp_valid, rsp_ack;
    logic [PAD-1:0] rsp_padding;
    logic [PKT-1:0] rsp_packet;
    state_e dbg_state;
`ifdef NOC_RESPONDER_LEN_CHECK_EN
    logic err;
`endif

    int total, bad, cyc, out_total;
    int ack_mode, ready_mode, rsp_mode, stall_left;
    flit_t          exp_out_q[$];
    logic [BW-1:0]  exp_req_q[$];
    logic [BW-1:0]  rsp_q[$];
    int             lat_q[$];
    int             last_in_cyc;

    noc_serial_responder #(
        .PACKET_BITS(PKT), .PADDING_BITS(PAD), .FLIT_DATA_BITS(FW),
        .OWN_ROW(OWN_R), .OWN_COL(OWN_C)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ack(in_ack),
        .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ack(out_ack),
        .req_valid(req_valid), .req_padding(req_padding), .req_packet(req_packet),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_padding(rsp_padding), .rsp_packet(rsp_packet),
        .rsp_ack(rsp_ack), .dbg_state(dbg_state)
`ifdef NOC_RESPONDER_LEN_CHECK_EN
        , .err(err)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic send_flit(input logic [FW-1:0] d, input logic l, input int gap);
        int n;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ack) begin
                last_in_cyc = cyc;
                break;
            end
            n++;
            if (n > 600) begin
                total++; bad++;
                $display("FAIL in_ack_timeout: got no ack expected ack within 600 cycles");
                break;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    // Model: request = the body word; response = header {src, own} plus the
    // user's reply word cut into FW-bit slices, LSB first.
    task automatic send_packet(input logic [3:0] dr, input logic [3:0] dc, input logic [3:0] sr,
                               input logic [3:0] sc, input logic [BW-1:0] word, input bit lat_chk,
                               input bit gaps);
        logic [NB*FW-1:0] ext, rext;
        logic [BW-1:0]    rsp;
        flit_t            f;
        rsp = BW'({$urandom(), $urandom()});
        exp_req_q.push_back(word);
        rsp_q.push_back(rsp);
        f.last = 1'b0;
        f.data = {sr, sc, OWN_R, OWN_C};
        exp_out_q.push_back(f);
        rext = (NB*FW)'(rsp);
        for (int i = 0; i < NB; i++) begin
            f.last = (i == NB - 1);
            f.data = rext[i*FW +: FW];
            exp_out_q.push_back(f);
        end
        ext = (NB*FW)'(word);
        send_flit({dr, dc, sr, sc}, 1'b0, gaps ? $urandom_range(0, 2) : 0);
        for (int i = 0; i < NB; i++) begin
            send_flit(ext[i*FW +: FW], i == NB - 1, gaps ? $urandom_range(0, 2) : 0);
        end
        lat_q.push_back(lat_chk ? last_in_cyc : -1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_out_q.size() != 0 || exp_req_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d out %0d req pending expected 0", exp_out_q.size(),
                     exp_req_q.size());
        end
        repeat (3) step();
    endtask

    // user side: request sink and response source
    initial begin : user_drv
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_padding = '0;
        rsp_packet  = '0;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ack && rsp_q.size() > 0) void'(rsp_q.pop_front());
            @(posedge clk);
            #1;
            req_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            rsp_valid = (rsp_q.size() > 0) && (rsp_mode == 0 || $urandom_range(0, 1) == 1);
            if (rsp_q.size() > 0) {rsp_padding, rsp_packet} = rsp_q[0];
        end
    end

    // mesh side: out_ack source, with an optional stall on the second body flit
    initial begin : ack_drv
        int pos;
        pos = 0;
        out_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = 0;
            end else begin
                if (ack_mode == 2 && out_valid && !out_ack && stall_left > 0) stall_left--;
                if (out_valid && out_ack) pos = (pos == NB) ? 0 : pos + 1;
            end
            @(posedge clk);
            #1;
            if (ack_mode == 1) out_ack = 1'($urandom_range(0, 1));
            else out_ack = !(ack_mode == 2 && pos == 2 && stall_left > 0);
        end
    end

    // scoreboard monitors
    initial begin : req_mon
        logic hold;
        logic [BW-1:0] held, e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) check("req_hold", {req_valid, req_padding, req_packet}, {1'b1, held});
                if (req_valid && req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL req_unexpected: got %0h expected none", {req_padding, req_packet});
                    end else begin
                        e = exp_req_q.pop_front();
                        check("req_word", {req_padding, req_packet}, e);
                    end
                end
                hold = req_valid && !req_ready;
                held = {req_padding, req_packet};
            end
        end
    end

    initial begin : out_mon
        int pos, l;
        logic hold;
        logic [FW-1:0] held;
        flit_t e;
        pos = 0;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = 0;
                hold = 1'b0;
            end else begin
                if (hold) check("out_hold", {out_valid, out_data}, {1'b1, held});
                if (out_valid && out_ack) begin
                    out_total++;
                    if (exp_out_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL out_unexpected: got %0h expected none", out_data);
                    end else begin
                        e = exp_out_q.pop_front();
                        check("out_flit", {out_last, out_data}, e);
                    end
                    if (pos == 0 && lat_q.size() > 0) begin
                        l = lat_q.pop_front();
                        if (l >= 0) check("latency", cyc - l, 3);
                    end
                    pos = (pos == NB) ? 0 : pos + 1;
                end
                hold = out_valid && !out_ack;
                held = out_data;
            end
        end
    end

    // main sequence
    initial begin : main_seq
        int base;
        logic [NB*FW-1:0] ext;
        total = 0; bad = 0; cyc = 0; out_total = 0;
        ack_mode = 0; ready_mode = 0; rsp_mode = 0; stall_left = 0;
        rst = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b0;
        in_data = 16'hFFFF;
        repeat (3) step();
        @(negedge clk);
        check("rst_in_ack", in_ack, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_req_word", {req_padding, req_packet}, 0);
        check("rst_rsp_ack", rsp_ack, 0);
        check("rst_state", dbg_state, RX_HEAD);
`ifdef NOC_RESPONDER_LEN_CHECK_EN
        check("rst_err", err, 0);
`endif
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        step();

        // directed known packet: header 0x0012, packet 0x2AAAAAAAAAA, padding 0x5
        send_packet(4'h0, 4'h0, 4'h1, 4'h2, {4'h5, 42'h2AAAAAAAAAA}, 1'b1, 1'b0);
        wait_idle();

        // request held off by the user: input must stay back-pressured
        ready_mode = 2;
        send_packet(4'h3, 4'h1, 4'h7, 4'h9, BW'({$urandom(), $urandom()}), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h5A5A;
        in_last  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("stall_in_ack", in_ack, 0);
            check("stall_req_valid", req_valid, 1);
            step();
        end
        in_valid = 1'b0;
        ready_mode = 0;
        send_packet(4'h5, 4'hA, 4'h5, 4'h5, BW'({$urandom(), $urandom()}), 1'b0, 1'b0);
        wait_idle();

        // out_ack low for 5 cycles on the second body flit
        ack_mode = 2;
        stall_left = 5;
        base = out_total;
        send_packet(4'h0, 4'h0, 4'hC, 4'h3, BW'({$urandom(), $urandom()}), 1'b0, 1'b0);
        wait_idle();
        check("stall_out_count", out_total - base, NB + 1);
        check("stall_consumed", stall_left, 0);
        ack_mode = 0;

        // reset on body flit 2 discards the partial request
        ext = (NB*FW)'(BW'({$urandom(), $urandom()}));
        send_flit(16'h0034, 1'b0, 0);
        send_flit(ext[FW-1:0], 1'b0, 0);
        in_valid = 1'b1;
        in_data  = ext[2*FW-1:FW];
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_req_valid", req_valid, 0);
        check("post_rst_state", dbg_state, RX_HEAD);
        step();
        send_packet(4'h0, 4'h0, 4'h2, 4'h4, BW'({$urandom(), $urandom()}), 1'b1, 1'b0);
        wait_idle();

`ifdef NOC_RESPONDER_LEN_CHECK_EN
        // in_last on body flit 1 is a framing error
        send_flit(16'h0056, 1'b0, 0);
        send_flit(16'h1234, 1'b1, 0);
        @(negedge clk);
        check("err_pulse", err, 1);
        check("err_state", dbg_state, RX_HEAD);
        step();
        @(negedge clk);
        check("err_clear", err, 0);
        check("err_no_req", req_valid, 0);
        step();
`endif

        // two back-to-back packets, all handshakes high
        send_packet(4'h1, 4'h1, 4'h8, 4'h1, BW'({$urandom(), $urandom()}), 1'b1, 1'b0);
        send_packet(4'h2, 4'h2, 4'h9, 4'h2, BW'({$urandom(), $urandom()}), 1'b1, 1'b0);
        wait_idle();

        // random traffic
        for (int p = 0; p < 25; p++) begin
            ack_mode   = $urandom_range(0, 1);
            ready_mode = $urandom_range(0, 1);
            rsp_mode   = $urandom_range(0, 1);
            send_packet(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                        BW'({$urandom(), $urandom()}), 1'b0, 1'b1);
        end
        wait_idle();
        ack_mode = 0; ready_mode = 0; rsp_mode = 0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_serial_responder.md
NOC_SERIAL_RESPONDER -- requirements
Module: noc_serial_responder

Interface
REQ-001 Parameter PACKET_BITS, default 42, payload width in bits.
REQ-002 Parameter PADDING_BITS, default 4, padding width in bits.
REQ-003 Parameter FLIT_DATA_BITS, default 16, flit data width in bits.
REQ-004 Parameters OWN_ROW and OWN_COL, default 0 and 0, 4-bit mesh address of this endpoint.
REQ-005 clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid, in_last, in_data  in  1, 1, FLIT_DATA_BITS  incoming flit from the mesh.
REQ-008 in_ack  out  1  flit accepted in this cycle.
REQ-009 out_valid, out_last, out_data  out  1, 1, FLIT_DATA_BITS  outgoing flit to the mesh.
REQ-010 out_ack  in  1  mesh accepted the outgoing flit.
REQ-011 req_valid, req_padding, req_packet  out  1, PADDING_BITS, PACKET_BITS  received request presented to the user.
REQ-012 req_ready  in  1  user takes the request.
REQ-013 rsp_valid, rsp_padding, rsp_packet  in  1, PADDING_BITS, PACKET_BITS  user response.
REQ-014 rsp_ack  out  1  response captured.

Function
REQ-015 The block SHALL transfer a flit only in a cycle where valid and ack are both high.
REQ-016 Packet format SHALL be:
- Header flit: [15:12] dst_row, [11:8] dst_col, [7:4] src_row, [3:0] src_col.
- NB = ceil((PADDING_BITS+PACKET_BITS)/FLIT_DATA_BITS) body flits (3 at defaults).
- Body word {padding, packet} is carried LSB-first and zero-extended.
- in_last/out_last SHALL be high only on the final body flit.
REQ-017 The FSM SHALL have exactly these states and transitions:
- RX_HEAD -> RX_BODY on header accept, latching src_row/src_col.
- RX_BODY -> REQ after NB flits.
- REQ -> WAIT_RSP on req_valid&&req_ready.
- WAIT_RSP -> TX_HEAD on rsp_valid, capturing the response.
- TX_HEAD -> TX_BODY on header handshake.
- TX_BODY -> RX_HEAD on the last handshake.
REQ-018 in_ack SHALL be high only in RX_HEAD and RX_BODY, combinationally equal to in_valid.
REQ-019 req_valid SHALL be high only in REQ, with req_padding and req_packet stable until the handshake.
REQ-020 rsp_ack SHALL be a one-cycle pulse in the cycle rsp_valid is sampled in WAIT_RSP.
REQ-021 The response header SHALL carry dst = latched src and src = {OWN_ROW, OWN_COL}.
REQ-022 out_valid SHALL stay high and out_data SHALL stay stable while out_ack is low.
REQ-023 Minimum latency from the last input flit to the first output flit SHALL be 3 cycles, with req_ready and rsp_valid both held high.
REQ-024 The body-flit counter SHALL be $clog2(NB+1) bits wide and SHALL clear on every header transfer.
REQ-025 Header flits with dst not equal to {OWN_ROW, OWN_COL} SHALL still be accepted, processed and answered; routing is the mesh's job.
REQ-026 At most one request SHALL be in flight; input flits SHALL be back-pressured from REQ through TX_BODY.

Reset
REQ-027 On rst, the FSM SHALL enter RX_HEAD and the counter and latched source SHALL clear.
REQ-028 On rst, in_ack, out_valid, out_last, req_valid and rsp_ack SHALL be 0, and out_data, req_padding and req_packet SHALL be all-zero.
REQ-029 rst mid-packet SHALL discard the partial request or response; no flit SHALL be emitted in the cycle after reset.

Configuration
REQ-030 With NOC_RESPONDER_LEN_CHECK_EN defined, the block SHALL add output err (1 bit) and detect framing errors:
- Error cases: in_last high before body flit NB, or low on body flit NB.
- Response: pulse err for 1 cycle, drop the packet, return to RX_HEAD, and issue no req_valid.
REQ-031 Without the macro, in_last SHALL be ignored, NB SHALL be counted blindly, and no err port SHALL exist.

Structure
REQ-032 A shared package noc_serial_pkg SHALL hold:
- the header field offsets and the addr_t (4-bit) typedef;
- the flit_t struct {last, data};
- the NB computation function.
REQ-033 One sub-module, noc_flit_shifter, SHALL handle serialisation and deserialisation, parameterised by direction and shared with the existing sender and receiver.

Verification
REQ-034 Header 0x0012 followed by 3 body flits encoding packet 0x2AAAAAAAAAA and padding 0x5 SHALL produce:
- req_packet = 0x2AAAAAAAAAA and req_padding = 0x5;
- a response header of 0x1200 at OWN = (0,0).
REQ-035 With out_ack held low for 5 cycles on the second body flit, out_data SHALL be stable throughout and exactly 4 total out flits SHALL be counted.
REQ-036 With req_ready low for 10 cycles, in_ack SHALL stay 0 even with in_valid high, and no flit SHALL be lost.
REQ-037 rst asserted on body flit 2 SHALL produce no req_valid; a following clean packet SHALL complete normally.
REQ-038 With the macro defined, in_last on body flit 1 SHALL produce err = 1 for one cycle, no req_valid, and the FSM SHALL return to RX_HEAD.
REQ-039 Two back-to-back packets with all handshakes held high SHALL produce two responses in order, each reaching its first out flit 3 cycles after its last input flit.
